// File: rtl/addwm_blend_engine.sv
// Watermark blend engine: loads a watermark tile into a local buffer, then mixes it lane-wise into the image stream.
// Latency: 2 cycles from image handshake to out_tvalid; one tile word is read per accepted image beat.
// Backpressure: out_tvalid && !out_tready freezes the whole pipe and drops im_tready; wm_tready is 1 throughout LOAD.
// Ports: ap_clk/areset (sync, active-high); ap_start/ap_done/busy job control;
//        ctrl_* job parameters latched at start; wm_* watermark stream in; im_* image stream in;
//        out_* blended stream out; err_wm_ovf sticky flag for a watermark larger than the tile buffer.
module addwm_blend_engine #(
  parameter int C_IM_DATA_WIDTH = 512,
  parameter int C_WM_DATA_WIDTH = 128,
  parameter int C_PIXEL_WIDTH   = 8,
  parameter int C_WM_BUF_DEPTH  = 256
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       busy,
  input  logic [1:0]                 ctrl_mode,
  input  logic [7:0]                 ctrl_strength,
  input  logic [31:0]                ctrl_wm_beats,
  input  logic [31:0]                ctrl_im_beats,
  input  logic                       wm_tvalid,
  output logic                       wm_tready,
  input  logic [C_WM_DATA_WIDTH-1:0] wm_tdata,
  input  logic                       wm_tlast,
  input  logic                       im_tvalid,
  output logic                       im_tready,
  input  logic [C_IM_DATA_WIDTH-1:0] im_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [C_IM_DATA_WIDTH-1:0] out_tdata,
  output logic                       out_tlast,
  output logic                       err_wm_ovf
);
  localparam int RATIO = C_IM_DATA_WIDTH / C_WM_DATA_WIDTH;
  localparam int LANES = C_IM_DATA_WIDTH / C_PIXEL_WIDTH;
  localparam int P     = C_PIXEL_WIDTH;
  localparam int AW    = $clog2(C_WM_BUF_DEPTH);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(RATIO - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  // Job parameters latched at start
  logic [1:0]  mode_q;
  logic        bypass_q;
  logic [7:0]  strength_q;
  logic [31:0] wm_beats_q, im_beats_q;

  // Load side
  logic [31:0]                wm_cnt;
  logic [AW:0]                wr_ptr;    // reaches C_WM_BUF_DEPTH when the buffer is full
  logic [SW-1:0]              sub_idx;
  logic [C_IM_DATA_WIDTH-1:0] acc, acc_nxt;
  logic [AW:0]                tile_len;
  logic [C_IM_DATA_WIDTH-1:0] tile_mem [C_WM_BUF_DEPTH];

  // Mix side
  logic [31:0]                im_cnt;
  logic [AW-1:0]              rd_idx;
  logic [AW:0]                rd_nxt;
  logic                       s1_vld, s1_last;
  logic [C_IM_DATA_WIDTH-1:0] s1_im, s1_w, mix_dat;

  logic wm_hs, wm_last, group_done, buf_full;
  logic im_hs, im_last, stall;

  assign wm_tready  = (state == S_LOAD);
  assign wm_hs      = wm_tvalid & wm_tready;
  assign wm_last    = wm_tlast | ((wm_cnt + 32'd1) == wm_beats_q);
  assign group_done = (sub_idx == SUB_LAST) | wm_last;
  assign buf_full   = wr_ptr[AW];

  assign stall     = out_tvalid & ~out_tready;
  assign im_tready = (state == S_MIX) & ~stall;
  assign im_hs     = im_tvalid & im_tready;
  assign im_last   = (im_cnt + 32'd1) == im_beats_q;

  assign ap_done = (state == S_DONE);
  assign busy    = (state == S_LOAD) | (state == S_MIX) | (state == S_DRAIN);

  assign rd_nxt = {1'b0, rd_idx} + (AW+1)'(1);

  // Insert the incoming beat into its little-endian slot of the word being assembled
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(sub_idx)*C_WM_DATA_WIDTH +: C_WM_DATA_WIDTH] = wm_tdata;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ap_start) begin
        if (ctrl_wm_beats != 32'd0 && !ctrl_mode[1]) state_nxt = S_LOAD;
        else if (ctrl_im_beats != 32'd0)             state_nxt = S_MIX;
        else                                         state_nxt = S_DRAIN;
      end
      S_LOAD:  if (wm_hs && wm_last) state_nxt = (im_beats_q != 32'd0) ? S_MIX : S_DRAIN;
      S_MIX:   if (im_hs && im_last) state_nxt = S_DRAIN;
      S_DRAIN: if (!s1_vld && !out_tvalid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  function automatic logic [P-1:0] blend_lane(input logic [P-1:0] i, input logic [P-1:0] w,
                                              input logic [7:0] s, input logic alpha);
    logic [P+7:0] p_ws, p_is;
    logic [P+8:0] sum;
    p_ws = (P+8)'(w) * (P+8)'(s);
    p_is = (P+8)'(i) * (P+8)'(9'd256 - {1'b0, s});
    if (alpha) begin
      sum = (P+9)'(p_is) + (P+9)'(p_ws);
      return sum[P+7:8];
    end
    sum = (P+9)'(i) + (P+9)'(p_ws >> 8);
    return (sum > (P+9)'({P{1'b1}})) ? {P{1'b1}} : sum[P-1:0];
  endfunction

  always_comb begin
    mix_dat = s1_im;
    if (!bypass_q)
      for (int l = 0; l < LANES; l++)
        mix_dat[l*P +: P] = blend_lane(s1_im[l*P +: P], s1_w[l*P +: P], strength_q, mode_q == 2'd1);
  end

  // Tile buffer and stage-1 data carry no reset; their valid bits gate them
  always_ff @(posedge ap_clk) begin
    if (wm_hs && !buf_full && group_done) tile_mem[wr_ptr[AW-1:0]] <= acc_nxt;
    if (im_hs) begin
      s1_im <= im_tdata;
      s1_w  <= tile_mem[rd_idx];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      mode_q     <= '0;
      bypass_q   <= 1'b0;
      strength_q <= '0;
      wm_beats_q <= '0;
      im_beats_q <= '0;
      wm_cnt     <= '0;
      wr_ptr     <= '0;
      sub_idx    <= '0;
      acc        <= '0;
      tile_len   <= '0;
      im_cnt     <= '0;
      rd_idx     <= '0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
      err_wm_ovf <= 1'b0;
    end else begin
      if (state == S_IDLE && ap_start) begin
        mode_q     <= ctrl_mode;
        // An empty watermark has nothing to blend, so it behaves like bypass
        bypass_q   <= ctrl_mode[1] | (ctrl_wm_beats == 32'd0);
        strength_q <= ctrl_strength;
        wm_beats_q <= ctrl_wm_beats;
        im_beats_q <= ctrl_im_beats;
        wm_cnt     <= '0;
        wr_ptr     <= '0;
        sub_idx    <= '0;
        acc        <= '0;
        tile_len   <= '0;
        im_cnt     <= '0;
        rd_idx     <= '0;
        err_wm_ovf <= 1'b0;
      end

      if (wm_hs) begin
        wm_cnt <= wm_cnt + 32'd1;
        if (buf_full) begin
          err_wm_ovf <= 1'b1;
        end else if (group_done) begin
          wr_ptr  <= wr_ptr + (AW+1)'(1);
          acc     <= '0;
          sub_idx <= '0;
        end else begin
          acc     <= acc_nxt;
          sub_idx <= sub_idx + SW'(1);
        end
        if (wm_last) tile_len <= buf_full ? wr_ptr : wr_ptr + (AW+1)'(1);
      end

      if (im_hs) begin
        im_cnt <= im_cnt + 32'd1;
        rd_idx <= (rd_nxt >= tile_len) ? '0 : rd_nxt[AW-1:0];
      end

      if (!stall) begin
        s1_vld     <= im_hs;
        s1_last    <= im_hs & im_last;
        out_tvalid <= s1_vld;
        out_tlast  <= s1_vld & s1_last;
        if (s1_vld) out_tdata <= mix_dat;
      end
    end
  end
endmodule

// File: tb/tb_addwm_blend_engine.sv
module tb_addwm_blend_engine;
  localparam int IMW = 512;
  localparam int WMW = 128;
  localparam int LANES = 64;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic           areset = 1'b1;
  logic           ap_start = 1'b0;
  logic           ap_done, busy;
  logic [1:0]     ctrl_mode = '0;
  logic [7:0]     ctrl_strength = '0;
  logic [31:0]    ctrl_wm_beats = '0, ctrl_im_beats = '0;
  logic           wm_tvalid = 1'b0, wm_tready, wm_tlast = 1'b0;
  logic [WMW-1:0] wm_tdata = '0;
  logic           im_tvalid = 1'b0, im_tready;
  logic [IMW-1:0] im_tdata = '0;
  logic           out_tvalid, out_tready = 1'b0, out_tlast;
  logic [IMW-1:0] out_tdata;
  logic           err_wm_ovf;

  addwm_blend_engine dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done), .busy(busy),
    .ctrl_mode(ctrl_mode), .ctrl_strength(ctrl_strength),
    .ctrl_wm_beats(ctrl_wm_beats), .ctrl_im_beats(ctrl_im_beats),
    .wm_tvalid(wm_tvalid), .wm_tready(wm_tready), .wm_tdata(wm_tdata), .wm_tlast(wm_tlast),
    .im_tvalid(im_tvalid), .im_tready(im_tready), .im_tdata(im_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .err_wm_ovf(err_wm_ovf)
  );

  int checks = 0;
  int failures = 0;

  logic [WMW-1:0] wm_arr  [0:1039];
  logic [IMW-1:0] im_arr  [0:299];
  logic [IMW-1:0] exp_arr [0:299];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] s;
    int         wm_ctrl;
    int         wm_send;
    bit         tlast;
    int         im_n;
    logic [7:0] wb;
    logic [7:0] ib;
    logic [7:0] eb;
    int         rdy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [IMW+1:0] act, input logic [IMW+1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One job: start, stream wm_arr/im_arr, check out beats against exp_arr.
  // abort_wm>0 returns right after that many wm beats were accepted (leaving the job running).
  task automatic run_job(input string nm, input logic [1:0] mode, input logic [7:0] s,
                         input int wm_ctrl, input int wm_send, input bit use_tlast,
                         input int im_n, input int rdy_pct, input int abort_wm,
                         input bit exp_err, output int done_cyc);
    int  wi, ii, oi;
    bit  done, prev_stall, prev_last;
    logic [IMW-1:0] prev_dat;
    wi = 0; ii = 0; oi = 0; done = 0; prev_stall = 0; prev_last = 0; prev_dat = '0; done_cyc = -1;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; ctrl_mode = mode; ctrl_strength = s;
    ctrl_wm_beats = wm_ctrl; ctrl_im_beats = im_n;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      wm_tvalid  = (wi < wm_send);
      wm_tdata   = (wi < wm_send) ? wm_arr[wi] : '0;
      wm_tlast   = use_tlast && (wi == wm_send - 1);
      im_tvalid  = (ii < im_n);
      im_tdata   = (ii < im_n) ? im_arr[ii] : '0;
      out_tready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge ap_clk);
      if (cyc == 1) chk({nm, "_busy"}, busy, 1);
      if (wm_tvalid && wm_tready) wi++;
      if (im_tvalid && im_tready) ii++;
      if (prev_stall) chk({nm, "_stall_hold"}, {out_tvalid, prev_last, out_tdata}, {1'b1, out_tlast, prev_dat});
      if (out_tvalid && out_tready) begin
        if (oi < im_n) chk($sformatf("%s_beat%0d", nm, oi), {1'b1, out_tlast, out_tdata},
                           {1'b1, (oi == im_n - 1), exp_arr[oi]});
        else chk({nm, "_extra_beat"}, oi, im_n);
        oi++;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_last  = out_tlast;
      prev_dat   = out_tdata;
      if (ap_done) begin done = 1; done_cyc = cyc; end
      @(posedge ap_clk); #1;
      if (abort_wm > 0 && wi >= abort_wm) return;
    end
    wm_tvalid = 1'b0; wm_tlast = 1'b0; im_tvalid = 1'b0; out_tready = 1'b1;
    if (!done) begin
      failures++; checks++;
      $display("FAIL %s_timeout ap_done not seen, required within 3000 cycles", nm);
      return;
    end
    @(negedge ap_clk);
    chk({nm, "_done_pulse"}, {ap_done, busy}, 2'b00);
    chk({nm, "_out_count"}, oi, im_n);
    chk({nm, "_wm_accepted"}, wi, wm_send);
    chk({nm, "_err"}, err_wm_ovf, exp_err);
  endtask

  initial begin
    int dc;
    logic [7:0] b;

    //            mode   s      wmc  wms tl  im  wb     ib     eb     rdy
    vecs[0]  = '{2'd0, 8'd128, 8,   8,  1, 4, 8'h40, 8'hF0, 8'hFF, 100};
    vecs[1]  = '{2'd1, 8'd64,  4,   4,  0, 4, 8'h80, 8'h00, 8'h20, 30};
    vecs[2]  = '{2'd2, 8'd200, 4,   0,  0, 3, 8'h55, 8'h37, 8'h37, 70};
    vecs[3]  = '{2'd0, 8'd255, 0,   0,  0, 3, 8'h00, 8'h37, 8'h37, 100};
    vecs[4]  = '{2'd3, 8'd128, 4,   0,  0, 2, 8'h55, 8'h9A, 8'h9A, 50};
    vecs[5]  = '{2'd0, 8'd64,  100, 8,  1, 5, 8'h40, 8'h10, 8'h20, 60};
    vecs[6]  = '{2'd1, 8'd0,   4,   4,  0, 3, 8'hFF, 8'hC3, 8'hC3, 100};
    vecs[7]  = '{2'd1, 8'd255, 4,   4,  0, 3, 8'hFF, 8'h00, 8'hFE, 40};
    vecs[8]  = '{2'd0, 8'd255, 4,   4,  0, 3, 8'h01, 8'hFE, 8'hFE, 100};
    vecs[9]  = '{2'd0, 8'd255, 4,   4,  0, 3, 8'hFF, 8'h01, 8'hFF, 100};
    vecs[10] = '{2'd0, 8'd16,  4,   4,  0, 3, 8'hFF, 8'hF5, 8'hFF, 80};
    vecs[11] = '{2'd1, 8'd128, 4,   4,  0, 6, 8'h10, 8'h30, 8'h20, 25};

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_state", {ap_done, busy, wm_tready, im_tready, out_tvalid, out_tlast, err_wm_ovf}, '0);
    @(posedge ap_clk); #1;
    areset = 1'b0;

    // Reset in the middle of LOAD after three watermark beats
    for (int k = 0; k < 8; k++) wm_arr[k] = {16{8'h40}};
    run_job("rst_mid", 2'd0, 8'd128, 8, 8, 1, 4, 100, 3, 0, dc);
    areset = 1'b1; wm_tvalid = 1'b0; wm_tlast = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_mid_load", {ap_done, busy, wm_tready, im_tready, out_tvalid, out_tlast, err_wm_ovf}, '0);
    @(posedge ap_clk); #1;
    areset = 1'b0;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].wm_send; k++) wm_arr[k] = {16{vecs[v].wb}};
      for (int m = 0; m < vecs[v].im_n; m++) begin
        im_arr[m]  = {LANES{vecs[v].ib}};
        exp_arr[m] = {LANES{vecs[v].eb}};
      end
      run_job($sformatf("vec%0d", v), vecs[v].mode, vecs[v].s, vecs[v].wm_ctrl, vecs[v].wm_send,
              vecs[v].tlast, vecs[v].im_n, vecs[v].rdy, 0, 0, dc);
    end

    // Two wm beats: one tile word, upper half zero-padded, reused for every image beat
    wm_arr[0] = {16{8'h11}};
    wm_arr[1] = {16{8'h22}};
    for (int m = 0; m < 3; m++) begin
      for (int l = 0; l < LANES; l++) begin
        b = 8'(m * 16 + l);
        im_arr[m][l*8 +: 8]  = b;
        exp_arr[m][l*8 +: 8] = (l < 16) ? b + 8'd8 : (l < 32) ? b + 8'd17 : b;
      end
    end
    run_job("pad2", 2'd0, 8'd128, 2, 2, 0, 3, 100, 0, 0, dc);

    // Watermark overflow: 1040 beats into a 256-word tile, tile wraps after 256 image beats
    for (int k = 0; k < 1040; k++) wm_arr[k] = (k < 1024) ? {16{8'(k / 4)}} : {16{8'hEE}};
    for (int m = 0; m < 257; m++) begin
      im_arr[m]  = {LANES{8'h10}};
      exp_arr[m] = {LANES{8'(16 + (m % 256) / 2)}};
    end
    run_job("ovf", 2'd0, 8'd128, 1040, 1040, 1, 257, 100, 0, 1, dc);

    // Empty image: straight through DRAIN to DONE, error flag cleared by the new start
    run_job("im0", 2'd0, 8'd128, 0, 0, 0, 0, 100, 0, 0, dc);
    chk("im0_done_latency", (dc >= 1 && dc <= 4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
